jt12_timer_regs: RTL
====================

JT12_TIMER_REGS -- requirements
Module: jt12_timer_regs

Interface
REQ-001 Parameter: BUSY_CYCLES, default 32, number of clk_en ticks the busy flag stays high after a data write.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 clk_en  input  1  chip clock enable; gates the busy countdown and the CSM key-on only.
REQ-005 din  input  8  CPU write data.
REQ-006 addr  input  2  addr[0]: 0 = address port, 1 = data port; addr[1]: bank select (0 = bank holding timer registers).
REQ-007 cs_n, wr_n  input  1 each  active-low chip select and write strobe.
REQ-008 dout  output  8  status byte {busy, 5'b0, flag_B, flag_A}.
REQ-009 flag_A, flag_B, overflow_A  input  1 each  timer status from the timer block.
REQ-010 value_A  output  10, value_B  output  8  timer reload values.
REQ-011 load_A, load_B, enable_irq_A, enable_irq_B  output  1 each  level controls to the timer block.
REQ-012 clr_flag_A, clr_flag_B  output  1 each  one-cycle flag clear pulses.
REQ-013 ch3_mode  output  2  channel-3 mode field; csm_keyon  output  1  CSM key-on pulse.

Function
REQ-014 A write event SHALL be detected on the first clk cycle where (cs_n|wr_n) is 0 after a cycle where it was 1; a held-low strobe SHALL produce exactly one write event.
REQ-015 Write event with addr[0]=0 SHALL latch din and addr[1] as the current register address; no busy change.
REQ-016 Write event with addr[0]=1 SHALL write din to the latched address, and SHALL start busy, in either bank.
REQ-017 Bank 0 decode: 0x24 -> value_A[9:2]; 0x25 -> value_A[1:0]=din[1:0]; 0x26 -> value_B; 0x27 -> ch3_mode=din[7:6], clr_flag_B=din[5], clr_flag_A=din[4], enable_irq_B=din[3], enable_irq_A=din[2], load_B=din[1], load_A=din[0]; all other addresses and bank 1 SHALL leave outputs unchanged.
REQ-018 Register outputs SHALL update on the clk edge following the write-event cycle (latency 1).
REQ-019 clr_flag_A/B SHALL be high exactly one clk cycle per 0x27 write with the bit set, and SHALL NOT be stored.
REQ-020 Busy SHALL be set with the counter loaded to BUSY_CYCLES on a data write, decremented on each clk_en while non-zero, and cleared when the counter reaches 0.
REQ-021 A data write while busy SHALL be accepted and SHALL reload the counter to BUSY_CYCLES.
REQ-022 dout SHALL be registered, updated every clk cycle from current busy, flag_B, flag_A.

Reset
REQ-023 rst SHALL clear all value, load, enable, ch3_mode, clr and csm_keyon outputs, the address latch, the busy counter, dout and the strobe history to 0; rst mid-write SHALL discard the write.

Configuration
REQ-024 With JT12_CSM_EN defined, csm_keyon SHALL pulse one clk cycle when clk_en and overflow_A are high and ch3_mode is 2'b10; without it, csm_keyon SHALL be constant 0 and ch3_mode SHALL still be stored and output.

Structure
REQ-025 Package jt12_timer_pkg SHALL hold register address constants (0x24-0x27), 0x27 bit positions, the CSM mode code and the BUSY_CYCLES default.
REQ-026 The busy counter SHALL be a sub-module jt12_busy_cnt (inputs start, clk_en; output busy).

Verification
REQ-027 Write addr 0x24 then data 0xAB, then 0x25/0x03 -> value_A = 0x2AF one cycle after the second data write.
REQ-028 Write 0x27/0x35 -> load_A=1, enable_irq_B=0, enable_irq_A=1, clr_flag_B and clr_flag_A high for exactly one cycle, then 0.
REQ-029 Data write with clk_en every cycle, BUSY_CYCLES=32 -> dout[7]=1 for 32 clk_en ticks, then 0; second write at tick 10 -> busy extends to tick 42.
REQ-030 Bank 1 address 0x26 write of 0x55 -> value_B unchanged, busy still set.
REQ-031 JT12_CSM_EN defined, ch3_mode=2'b10, overflow_A asserted with clk_en -> csm_keyon one-cycle pulse; ch3_mode=2'b01 -> no pulse; macro undefined -> never.
REQ-032 rst asserted during held-low wr_n -> all outputs 0, no write after rst release until wr_n rises and falls again.

Source files
------------

// File: rtl/jt12_timer_pkg.sv
// Shared constants for the YM2612-style timer register block.
// Register map, control-byte bit positions, CSM mode code and busy default.
package jt12_timer_pkg;

  localparam int BUSY_CYCLES_DEF = 32;

  localparam logic [7:0] ADDR_VAL_A_HI = 8'h24;
  localparam logic [7:0] ADDR_VAL_A_LO = 8'h25;
  localparam logic [7:0] ADDR_VAL_B    = 8'h26;
  localparam logic [7:0] ADDR_CTRL     = 8'h27;

  localparam int CTRL_LOAD_A   = 0;
  localparam int CTRL_LOAD_B   = 1;
  localparam int CTRL_IRQ_A    = 2;
  localparam int CTRL_IRQ_B    = 3;
  localparam int CTRL_CLR_A    = 4;
  localparam int CTRL_CLR_B    = 5;
  localparam int CTRL_CH3_LSB  = 6;

  localparam logic [1:0] CH3_MODE_CSM = 2'b10;

  // Latched register pointer: bank bit plus 8-bit register number.
  typedef struct packed {
    logic       bank;
    logic [7:0] num;
  } reg_ptr_t;

endpackage

// File: rtl/jt12_busy_cnt.sv
// Busy flag for the chip data port: a down-counter loaded on each data write
// and decremented on chip clock enables until it reaches zero.
module jt12_busy_cnt
  import jt12_timer_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clk_en,
  output logic busy
);

  localparam int CW = $clog2(BUSY_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(BUSY_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LOAD_VAL;
    end else if (clk_en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/jt12_timer_regs.sv
// CPU-facing register file for the timer block: address/data port decode,
// busy status and optional CSM key-on (enabled by defining JT12_CSM_EN).
module jt12_timer_regs
  import jt12_timer_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] din,
  input  logic [1:0] addr,
  input  logic       cs_n,
  input  logic       wr_n,
  output logic [7:0] dout,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       overflow_A,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic [1:0] ch3_mode,
  output logic       csm_keyon
);

  logic     we_n;
  logic     we_n_q;
  logic     write_ev;
  logic     data_ev;
  logic     busy;
  reg_ptr_t sel;

  // History resets low so a strobe held through reset must rise before it counts.
  assign we_n     = cs_n | wr_n;
  assign write_ev = ~we_n & we_n_q;
  assign data_ev  = write_ev & addr[0];

  jt12_busy_cnt #(
    .BUSY_CYCLES(BUSY_CYCLES)
  ) u_busy (
    .clk   (clk),
    .rst   (rst),
    .start (data_ev),
    .clk_en(clk_en),
    .busy  (busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      we_n_q       <= 1'b0;
      sel          <= '0;
      value_A      <= '0;
      value_B      <= '0;
      load_A       <= 1'b0;
      load_B       <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      ch3_mode     <= '0;
      dout         <= '0;
    end else begin
      we_n_q     <= we_n;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      dout       <= {busy, 5'b0, flag_B, flag_A};
      if (write_ev && !addr[0]) begin
        sel <= '{bank: addr[1], num: din};
      end
      if (data_ev && !sel.bank) begin
        case (sel.num)
          ADDR_VAL_A_HI: value_A[9:2] <= din;
          ADDR_VAL_A_LO: value_A[1:0] <= din[1:0];
          ADDR_VAL_B:    value_B      <= din;
          ADDR_CTRL: begin
            ch3_mode     <= din[CTRL_CH3_LSB +: 2];
            clr_flag_B   <= din[CTRL_CLR_B];
            clr_flag_A   <= din[CTRL_CLR_A];
            enable_irq_B <= din[CTRL_IRQ_B];
            enable_irq_A <= din[CTRL_IRQ_A];
            load_B       <= din[CTRL_LOAD_B];
            load_A       <= din[CTRL_LOAD_A];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef JT12_CSM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      csm_keyon <= 1'b0;
    end else begin
      csm_keyon <= clk_en & overflow_A & (ch3_mode == CH3_MODE_CSM);
    end
  end
`else
  logic unused_overflow_A;
  assign unused_overflow_A = overflow_A;
  assign csm_keyon         = 1'b0;
`endif

endmodule
